// File: rtl/rpc_ctrl_pkg.sv
// Shared DRAM width constants, command/beat structs and burst FSM state encoding
// for the RPC DRAM controller front-end.
package rpc_ctrl_pkg;

    localparam int unsigned DRAM_ALIGN_POS  = 5;
    localparam int unsigned DRAM_ADDR_WIDTH = 20;
    localparam int unsigned DRAM_WORD_WIDTH = 256;
    localparam int unsigned DRAM_MASK_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCmd   = 2'd1,
        StWrite = 2'd2,
        StRead  = 2'd3
    } burst_state_e;

    typedef struct packed {
        logic                       is_write;
        logic [DRAM_ALIGN_POS-1:0]  len;
        logic [DRAM_ADDR_WIDTH-1:0] addr;
    } dram_cmd_t;

    typedef struct packed {
        logic [DRAM_WORD_WIDTH-1:0] data;
        logic [DRAM_MASK_WIDTH-1:0] mask;
    } dram_wbeat_t;

endpackage

// File: rtl/rpc_burst_initiator.sv
// Burst initiator: accepts one client request, issues one controller command, then
// streams write beats out or read beats back until the burst ends.
module rpc_burst_initiator
    import rpc_ctrl_pkg::*;
#(
    parameter int unsigned DRAM_ALIGN_POS  = 5,
    parameter int unsigned DRAM_ADDR_WIDTH = 20,
    parameter int unsigned DRAM_WORD_WIDTH = 256,
    parameter int unsigned DRAM_MASK_WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_is_write_i,
    input  logic [DRAM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DRAM_ALIGN_POS-1:0]  req_len_i,

    input  logic                       wdata_valid_i,
    output logic                       wdata_ready_o,
    input  logic [DRAM_WORD_WIDTH-1:0] wdata_i,
    input  logic [DRAM_MASK_WIDTH-1:0] wmask_i,

    output logic                       rdata_valid_o,
    input  logic                       rdata_ready_i,
    output logic [DRAM_WORD_WIDTH-1:0] rdata_o,
    output logic                       rdata_last_o,

    output logic                       done_o,
    output logic                       err_o,

    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic                       cmd_is_write_o,
    output logic [DRAM_ALIGN_POS-1:0]  cmd_len_o,
    output logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_o,

    output logic                       phy_w_data_valid_o,
    input  logic                       phy_w_data_ready_i,
    output logic [DRAM_WORD_WIDTH-1:0] phy_w_data_o,
    output logic [DRAM_MASK_WIDTH-1:0] write_mask_o,

    input  logic                       phy_r_data_valid_i,
    output logic                       phy_r_data_ready_o,
    input  logic [DRAM_WORD_WIDTH-1:0] phy_r_data_i,
    input  logic                       phy_r_data_last_i
);

    localparam logic [DRAM_ALIGN_POS-1:0] CNT_MAX = '1;

    burst_state_e               r_state;
    logic                       r_is_write;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic [DRAM_ALIGN_POS-1:0]  r_len;
    logic [DRAM_ALIGN_POS-1:0]  r_cnt;
    logic                       r_done;
    logic                       r_err;

    logic w_req_hs;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_cnt_at_len;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign req_ready_o  = (r_state == StIdle) && rst_ni;
    assign w_req_hs     = req_valid_i && req_ready_o;
    assign w_wr_hs      = (r_state == StWrite) && wdata_valid_i && phy_w_data_ready_i;
    assign w_rd_hs      = (r_state == StRead) && phy_r_data_valid_i && rdata_ready_i;
    assign w_cnt_at_len = (r_cnt == r_len);

    assign cmd_valid_o    = (r_state == StCmd);
    assign cmd_is_write_o = r_is_write;
    assign cmd_len_o      = r_len;
    assign cmd_addr_o     = r_addr;
    assign done_o         = r_done;
    assign err_o          = r_err;

    always_comb begin
        phy_w_data_valid_o = 1'b0;
        wdata_ready_o      = 1'b0;
        phy_w_data_o       = '0;
        write_mask_o       = '0;
        if (r_state == StWrite) begin
            phy_w_data_valid_o = wdata_valid_i;
            wdata_ready_o      = phy_w_data_ready_i;
            phy_w_data_o       = wdata_i;
            write_mask_o       = wmask_i;
        end
    end

    always_comb begin
        rdata_valid_o      = 1'b0;
        phy_r_data_ready_o = 1'b0;
        rdata_o            = '0;
        rdata_last_o       = 1'b0;
        if (r_state == StRead) begin
            rdata_valid_o      = phy_r_data_valid_i;
            phy_r_data_ready_o = rdata_ready_i;
            rdata_o            = phy_r_data_i;
            rdata_last_o       = phy_r_data_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req_hs) begin
                        r_is_write <= req_is_write_i;
                        r_addr     <= req_addr_i;
                        r_len      <= req_len_i;
                        r_cnt      <= '0;
                        r_state    <= StCmd;
                    end
                end
                StCmd: begin
                    if (cmd_ready_i) begin
                        r_state <= r_is_write ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (w_wr_hs) begin
                        if (w_cnt_at_len) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (w_rd_hs) begin
                        if (phy_r_data_last_i) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                            r_err   <= !w_cnt_at_len;
                        end else begin
                            // Controller overran the requested length; keep draining until last.
                            r_err <= w_cnt_at_len;
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rpc_burst_initiator.md
RPC_BURST_INITIATOR -- requirements
Module: rpc_burst_initiator

Interface
REQ-001 SHALL have parameters DRAM_ALIGN_POS, default 5, beat-count field width; DRAM_ADDR_WIDTH, default 20, word address; DRAM_WORD_WIDTH, default 256, data word; DRAM_MASK_WIDTH, default 64, write mask.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-003 SHALL have these client request ports: req_valid_i in 1; req_ready_o out 1; req_is_write_i in 1 write/read select; req_addr_i in DRAM_ADDR_WIDTH start word; req_len_i in DRAM_ALIGN_POS beats minus one.
REQ-004 SHALL have these client write-data ports: wdata_valid_i in 1; wdata_ready_o out 1; wdata_i in DRAM_WORD_WIDTH; wmask_i in DRAM_MASK_WIDTH.
REQ-005 SHALL have these client read-data ports: rdata_valid_o out 1; rdata_ready_i in 1; rdata_o out DRAM_WORD_WIDTH; rdata_last_o out 1.
REQ-006 SHALL have these status ports: done_o out 1, burst-complete pulse; err_o out 1, read-length-mismatch pulse.
REQ-007 SHALL have these controller command ports: cmd_valid_o out 1; cmd_ready_i in 1; cmd_is_write_o out 1; cmd_len_o out DRAM_ALIGN_POS; cmd_addr_o out DRAM_ADDR_WIDTH.
REQ-008 SHALL have these controller write ports: phy_w_data_valid_o out 1; phy_w_data_ready_i in 1; phy_w_data_o out DRAM_WORD_WIDTH; write_mask_o out DRAM_MASK_WIDTH.
REQ-009 SHALL have these controller read ports: phy_r_data_valid_i in 1; phy_r_data_ready_o out 1; phy_r_data_i in DRAM_WORD_WIDTH; phy_r_data_last_i in 1.

Function
REQ-010 SHALL implement FSM states IDLE, CMD, WRITE, READ.
REQ-011 SHALL assert req_ready_o only in IDLE; on req_valid_i&&req_ready_o SHALL latch is_write/addr/len, clear beat counter, and enter CMD next cycle.
REQ-012 SHALL in CMD hold cmd_valid_o=1 with latched fields stable until cmd_ready_i; the first cmd_valid_o occurs the cycle after request acceptance.
REQ-013 SHALL on the command handshake enter WRITE if is_write, else READ.
REQ-014 SHALL in WRITE forward combinationally: phy_w_data_valid_o=wdata_valid_i, wdata_ready_o=phy_w_data_ready_i, phy_w_data_o=wdata_i, write_mask_o=wmask_i; outside WRITE both valid and ready SHALL be 0.
REQ-015 SHALL count write beats; on the handshake with count==len SHALL return to IDLE and pulse done_o for the following cycle.
REQ-016 SHALL in READ forward combinationally: rdata_valid_o=phy_r_data_valid_i, phy_r_data_ready_o=rdata_ready_i, rdata_o=phy_r_data_i, rdata_last_o=phy_r_data_last_i; outside READ both valid and ready SHALL be 0.
REQ-017 SHALL end READ on the handshake with phy_r_data_last_i=1 and pulse done_o the next cycle; if that handshake has count!=len, err_o SHALL pulse in the same cycle as done_o.
REQ-018 SHALL, on a handshake with count==len and last=0, pulse err_o the next cycle and stay in READ until last; the counter SHALL saturate at its maximum value and never wrap.
REQ-019 SHALL support len=0 (one beat) and len=2^DRAM_ALIGN_POS-1 (32 beats) with no counter overflow.
REQ-020 SHALL allow a new request to be accepted in the cycle done_o is high, giving a 1-cycle IDLE gap between bursts.

Reset
REQ-021 SHALL on rst_ni=0, asynchronously and at any state including mid-burst, enter IDLE, clear latched fields and counter, and drive every registered and valid/ready output to 0 except req_ready_o, which SHALL be 1 after reset release.
REQ-022 SHALL take no action on beats or handshakes arriving during reset.

Structure
REQ-023 SHALL take the command/phy struct typedefs, the DRAM width constants, and the FSM state enum from rpc_ctrl_pkg.
REQ-024 SHALL be a single module with no sub-modules.

Verification
REQ-025 Write burst, addr=0x00010, len=3, cmd_ready_i delayed 2 cycles -> cmd_valid_o held 3 cycles, 4 phy write beats with mask passed through, done_o pulses once.
REQ-026 Read burst, len=0 with last on beat 1 -> one rdata beat with rdata_last_o=1, done_o=1, err_o=0.
REQ-027 Read len=31 with random phy_r_data_valid_i/rdata_ready_i stalls -> 32 beats in order, no loss or duplication.
REQ-028 Read len=3 with last on beat 2 -> done_o and err_o pulse together; read len=1 with last on beat 3 -> err_o pulse after beat 2, done_o after beat 3.
REQ-029 rst_ni asserted during beat 2 of a write len=7 -> all outputs 0 immediately, req_ready_o=1 after release, and the next burst completes normally.
